// File: rtl/spi_reg_master.sv
// SPI initiator issuing single-register write/read frames to the SPI register-bank slave.
// Optional `SPI_MASTER_MISO_SYNC_EN adds a 2-flop synchronizer on spi_miso (needs CLK_DIV >= 3).
module spi_reg_master #(
    parameter int ADDR_W  = 4,
    parameter int REG_W   = 8,
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic [1:0]        mode,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [REG_W-1:0]  cmd_wdata,
    output logic              rsp_valid,
    output logic [REG_W-1:0]  rsp_rdata,
    output logic              busy,
    output logic              spi_cs_n,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso
);
    localparam int FRAME_W = 8 + REG_W;
    localparam int EDGES   = 2 * FRAME_W;
    localparam int CNT_W   = $clog2(CLK_DIV + CS_GAP + 1);
    localparam int EDGE_W  = $clog2(EDGES + 1);
    localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(CS_GAP - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(EDGES - 1);

    if (ADDR_W < 1 || ADDR_W > 7) begin : g_bad_addr_w
        $error("spi_reg_master: ADDR_W must be 1..7");
    end
    if (CLK_DIV < 1 || CS_GAP < 1) begin : g_bad_timing
        $error("spi_reg_master: CLK_DIV and CS_GAP must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [EDGE_W-1:0]   edge_q, edge_d;
    logic [1:0]          mode_q, mode_d;
    logic                write_q, write_d;
    logic [FRAME_W-1:0]  tx_q, tx_d;
    logic [REG_W-1:0]    rx_q, rx_d;
    logic                cs_n_q, cs_n_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [REG_W-1:0]    rdata_q, rdata_d;
    logic                busy_q, busy_d;

    logic [7:0]          cmd_byte_s;
    logic [FRAME_W-1:0]  frame_s;
    logic                lead_s;
    logic                samp_now_s;
    logic                capture_s;
    logic                miso_bit_s;

`ifdef SPI_MASTER_MISO_SYNC_EN
    if (CLK_DIV < 3) begin : g_bad_sync_div
        $error("spi_reg_master: CLK_DIV must be >= 3 with SPI_MASTER_MISO_SYNC_EN");
    end
    logic       miso_s1_q, miso_s1_d;
    logic       miso_s2_q, miso_s2_d;
    logic [1:0] samp_pipe_q, samp_pipe_d;
`endif

    assign cmd_ready = ena && (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign busy      = busy_q;
    assign spi_cs_n  = cs_n_q;
    assign spi_clk   = sclk_q;
    assign spi_mosi  = mosi_q;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        edge_d      = edge_q;
        mode_d      = mode_q;
        write_d     = write_q;
        tx_d        = tx_q;
        cs_n_d      = cs_n_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        busy_d      = busy_q;
        lead_s      = ~edge_q[0];
        samp_now_s  = 1'b0;

        cmd_byte_s    = 8'(cmd_addr);
        cmd_byte_s[7] = cmd_write;
        frame_s       = {cmd_byte_s, (cmd_write ? cmd_wdata : {REG_W{1'b0}})};

        case (state_q)
            IDLE: begin
                sclk_d = mode[1];
                cs_n_d = 1'b1;
                mosi_d = 1'b0;
                busy_d = 1'b0;
                if (cmd_valid && cmd_ready) begin
                    state_d = SETUP;
                    cnt_d   = {CNT_W{1'b0}};
                    mode_d  = mode;
                    write_d = cmd_write;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    // CPHA=0 presents the MSB before the first edge; CPHA=1 drives it on that edge
                    if (mode[0]) begin
                        tx_d   = frame_s;
                        mosi_d = 1'b0;
                    end else begin
                        tx_d   = frame_s << 1'b1;
                        mosi_d = frame_s[FRAME_W-1];
                    end
                end else begin
                    tx_d = tx_q;
                end
            end
            SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = SHIFT;
                    cnt_d   = {CNT_W{1'b0}};
                    edge_d  = {EDGE_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d  = {CNT_W{1'b0}};
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + EDGE_W'(1);
                    if (lead_s != mode_q[0]) begin
                        samp_now_s = 1'b1;
                    end else begin
                        mosi_d = tx_q[FRAME_W-1];
                        tx_d   = tx_q << 1'b1;
                    end
                    if (edge_q == EDGE_LAST) begin
                        state_d = HOLD;
                    end else begin
                        state_d = SHIFT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == DIV_LAST) begin
                    state_d     = GAP;
                    cnt_d       = {CNT_W{1'b0}};
                    cs_n_d      = 1'b1;
                    mosi_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    if (!write_q) begin
                        rdata_d = rx_q;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
                cs_n_d  = 1'b1;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // Disable aborts an active frame: bus goes idle at once, no response is produced
        if (!ena && (state_q == SETUP || state_q == SHIFT || state_q == HOLD)) begin
            state_d     = GAP;
            cnt_d       = {CNT_W{1'b0}};
            cs_n_d      = 1'b1;
            sclk_d      = mode_q[1];
            mosi_d      = 1'b0;
            rsp_valid_d = 1'b0;
            rdata_d     = rdata_q;
            samp_now_s  = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_d;
        end

`ifdef SPI_MASTER_MISO_SYNC_EN
        miso_s1_d   = spi_miso;
        miso_s2_d   = miso_s1_q;
        samp_pipe_d = {samp_pipe_q[0], samp_now_s};
        capture_s   = samp_pipe_q[1];
        miso_bit_s  = miso_s2_q;
`else
        capture_s   = samp_now_s;
        miso_bit_s  = spi_miso;
`endif
        if (capture_s) begin
            rx_d = (rx_q << 1'b1) | REG_W'(miso_bit_s);
        end else begin
            rx_d = rx_q;
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            edge_q      <= {EDGE_W{1'b0}};
            mode_q      <= 2'b00;
            write_q     <= 1'b0;
            tx_q        <= {FRAME_W{1'b0}};
            rx_q        <= {REG_W{1'b0}};
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= {REG_W{1'b0}};
            busy_q      <= 1'b0;
`ifdef SPI_MASTER_MISO_SYNC_EN
            miso_s1_q   <= 1'b0;
            miso_s2_q   <= 1'b0;
            samp_pipe_q <= 2'b00;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            edge_q      <= edge_d;
            mode_q      <= mode_d;
            write_q     <= write_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
`ifdef SPI_MASTER_MISO_SYNC_EN
            miso_s1_q   <= miso_s1_d;
            miso_s2_q   <= miso_s2_d;
            samp_pipe_q <= samp_pipe_d;
`endif
        end
    end

endmodule

// File: tb/tb_spi_reg_master.sv
// Directed bench for spi_reg_master with a behavioural SPI register-slave model.
`timescale 1ns/1ps
module tb_spi_reg_master;
`ifdef SPI_MASTER_MISO_SYNC_EN
    localparam int DIV = 3;
`else
    localparam int DIV = 1;
`endif
    localparam int GAP       = 2;
    localparam int FRAME_CYC = 1 + DIV * (2 * 16 + 2);

    logic       clk = 1'b0;
    logic       rstb;
    logic       ena;
    logic [1:0] mode;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       spi_cs_n;
    logic       spi_clk;
    logic       spi_mosi;
    logic       tb_miso = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    spi_reg_master #(.ADDR_W(4), .REG_W(8), .CLK_DIV(DIV), .CS_GAP(GAP)) u_dut (
        .clk(clk), .rstb(rstb), .ena(ena), .mode(mode),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(tb_miso)
    );

    // Slave model: frame starts on cs_n fall, samples MOSI / shifts MISO per mode
    logic [1:0]  tb_mode    = 2'b00;
    logic [15:0] slave_word = 16'h0000;
    logic [15:0] s_tx = 16'h0000;
    logic [15:0] s_rx = 16'h0000;
    int          s_bits = 0;
    logic        s_prev_cs = 1'b1;
    logic        s_clk_prev = 1'b0;
    logic        s_lead;

    always @(spi_clk or spi_cs_n) begin
        if (spi_cs_n) begin
            s_prev_cs = 1'b1;
        end else if (s_prev_cs) begin
            s_prev_cs  = 1'b0;
            s_bits     = 0;
            s_rx       = 16'h0000;
            s_tx       = slave_word;
            s_clk_prev = spi_clk;
            tb_miso    = tb_mode[0] ? 1'b0 : s_tx[15];
        end else if (spi_clk != s_clk_prev) begin
            s_clk_prev = spi_clk;
            s_lead     = (spi_clk != tb_mode[1]);
            if (s_lead != tb_mode[0]) begin
                s_rx   = {s_rx[14:0], spi_mosi};
                s_bits = s_bits + 1;
            end else if (tb_mode[0]) begin
                tb_miso = s_tx[15];
                s_tx    = {s_tx[14:0], 1'b0};
            end else begin
                s_tx    = {s_tx[14:0], 1'b0};
                tb_miso = s_tx[15];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!cmd_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
    endtask

    // One complete command; reports latency (accept -> rsp_valid), cs_n-high cycles and rdata at rsp
    task automatic run_cmd(input logic w, input logic [3:0] a, input logic [7:0] d,
                           input logic [1:0] m, input logic [7:0] sdat,
                           output int lat, output int hi, output logic [7:0] rd);
        logic seen;
        @(negedge clk);
        mode = m; tb_mode = m; slave_word = {8'h00, sdat};
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        wait_ready();
        @(negedge clk);
        cmd_valid = 1'b0;
        mode = ~m;
        check("ready_low_in_frame", {31'd0, cmd_ready}, 32'd0);
        lat = 1; hi = 0; seen = 1'b0; rd = 8'h00;
        while (lat < FRAME_CYC + 20) begin
            if (rsp_valid) begin
                seen = 1'b1;
                rd   = rsp_rdata;
                break;
            end
            if (spi_cs_n) hi++;
            @(negedge clk);
            lat++;
        end
        check("rsp_seen", {31'd0, seen}, 32'd1);
        check("cs_high_at_rsp", {31'd0, spi_cs_n}, 32'd1);
        @(negedge clk);
        check("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        int lat, hi, k, r, overlap, nrsp;
        logic [7:0] rd;
        rstb = 1'b0; ena = 1'b1; mode = 2'b00; cmd_valid = 1'b0;
        cmd_write = 1'b0; cmd_addr = 4'h0; cmd_wdata = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
        check("rst_sclk", {31'd0, spi_clk}, 32'd0);
        check("rst_mosi", {31'd0, spi_mosi}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rstb = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);

        // Mode 0 write addr 3 data A5; slave offers FF which must be ignored
        run_cmd(1'b1, 4'h3, 8'hA5, 2'b00, 8'hFF, lat, hi, rd);
        check("w0_mosi", {16'd0, s_rx}, 32'h83A5);
        check("w0_edges", s_bits, 32'd16);
        check("w0_latency", lat, FRAME_CYC);
        check("w0_cs_low", hi, 32'd0);
        check("w0_rdata", {24'd0, rd}, 32'd0);

        // Mode 3 read addr 9 -> 5A
        run_cmd(1'b0, 4'h9, 8'hEE, 2'b11, 8'h5A, lat, hi, rd);
        check("r3_mosi", {16'd0, s_rx}, 32'h0900);
        check("r3_rdata", {24'd0, rd}, 32'h5A);
        check("r3_latency", lat, FRAME_CYC);

        // Mode 1 and mode 2 reads
        run_cmd(1'b0, 4'h5, 8'h00, 2'b01, 8'h3C, lat, hi, rd);
        check("r1_mosi", {16'd0, s_rx}, 32'h0500);
        check("r1_rdata", {24'd0, rd}, 32'h3C);
        run_cmd(1'b0, 4'hF, 8'h00, 2'b10, 8'hC3, lat, hi, rd);
        check("r2_mosi", {16'd0, s_rx}, 32'h0F00);
        check("r2_rdata", {24'd0, rd}, 32'hC3);
        check("r2_cs_low", hi, 32'd0);

        // Write in mode 1: rdata must hold the last read value
        run_cmd(1'b1, 4'h0, 8'h01, 2'b01, 8'h99, lat, hi, rd);
        check("w1_mosi", {16'd0, s_rx}, 32'h8001);
        check("w1_rdata_hold", {24'd0, rd}, 32'hC3);

        // Back-to-back: command held valid across two frames
        @(negedge clk);
        mode = 2'b00; tb_mode = 2'b00; slave_word = 16'h0000;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h2; cmd_wdata = 8'h11;
        wait_ready();
        @(negedge clk);
        k = 0; overlap = 0;
        while (!spi_cs_n && k < FRAME_CYC + 20) begin
            if (cmd_ready) overlap++;
            @(negedge clk);
            k++;
        end
        check("b2b_busy_in_gap", {31'd0, busy}, 32'd1);
        r = 0;
        while (!cmd_ready && r < 50) begin
            @(negedge clk);
            r++;
        end
        check("b2b_gap_cycles", r, GAP);
        check("b2b_ready_while_busy", overlap, 32'd0);
        check("b2b_busy_idle", {31'd0, busy}, 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b_second_cs", {31'd0, spi_cs_n}, 32'd0);
        k = 0;
        while (!rsp_valid && k < FRAME_CYC + 20) begin
            @(negedge clk);
            k++;
        end
        check("b2b_second_mosi", {16'd0, s_rx}, 32'h8211);

        // ena dropped after bit 5 of a mode 0 read
        @(negedge clk);
        mode = 2'b00; tb_mode = 2'b00; slave_word = 16'h0077;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h4;
        wait_ready();
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (s_bits < 5 && k < 200) begin
            @(negedge clk);
            k++;
        end
        ena = 1'b0;
        @(negedge clk);
        check("abort_cs_n", {31'd0, spi_cs_n}, 32'd1);
        check("abort_sclk", {31'd0, spi_clk}, 32'd0);
        check("abort_mosi", {31'd0, spi_mosi}, 32'd0);
        nrsp = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) nrsp++;
            @(negedge clk);
        end
        check("abort_no_rsp", nrsp, 32'd0);
        check("abort_rdata_kept", {24'd0, rsp_rdata}, 32'hC3);
        check("abort_busy_done", {31'd0, busy}, 32'd0);
        check("abort_ready_ena_low", {31'd0, cmd_ready}, 32'd0);
        ena = 1'b1;
        run_cmd(1'b0, 4'h4, 8'h00, 2'b00, 8'h77, lat, hi, rd);
        check("post_abort_mosi", {16'd0, s_rx}, 32'h0400);
        check("post_abort_rdata", {24'd0, rd}, 32'h77);
        check("post_abort_latency", lat, FRAME_CYC);

        // Asynchronous reset in the middle of a mode 2 write
        @(negedge clk);
        mode = 2'b10; tb_mode = 2'b10; slave_word = 16'h0000;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h6; cmd_wdata = 8'h3E;
        wait_ready();
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (DIV * 6) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 rstb = 1'b0;
        #1;
        check("arst_cs_n", {31'd0, spi_cs_n}, 32'd1);
        check("arst_sclk", {31'd0, spi_clk}, 32'd0);
        check("arst_mosi", {31'd0, spi_mosi}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_rdata", {24'd0, rsp_rdata}, 32'd0);
        check("arst_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        rstb = 1'b1;
        run_cmd(1'b1, 4'h6, 8'h3E, 2'b00, 8'h00, lat, hi, rd);
        check("post_rst_mosi", {16'd0, s_rx}, 32'h863E);
        check("post_rst_latency", lat, FRAME_CYC);
        check("post_rst_cs_low", hi, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
